ccc_tick_gen: RTL and testbench
===============================

Name: ccc_tick_gen

Overview:
- Parametrised successor to the fixed single-output FCCC clock wrapper.
- Runs on the conditioned global clock (GL0) and qualifies the CCC LOCK signal.
- Generates NUM_CH independently programmable clock-enable tick strobes for downstream blocks such as echo timing, PWM and sensor sampling.
- Divisor reprogramming is glitch-free, and loss-of-lock is reported through a sticky flag.

Parameters:
- NUM_CH, 4: number of tick channels (1..8).
- DIV_W, 16: divisor width per channel.
- LOCK_FILTER, 8: consecutive synchronized LOCK-high cycles required before CLK_OK asserts (1..255).
- DIV_RST, 1000: reset divisor value loaded into every channel.

Ports:
- CLK  in  1  system clock; GL0 from the FCCC.
- RESETN  in  1  synchronous, active-low reset.
- LOCK  in  1  raw CCC lock; asynchronous to CLK.
- EN  in  NUM_CH  per-channel run enable.
- DIV_LD  in  NUM_CH  per-channel divisor load strobe, one cycle.
- DIV_VAL  in  NUM_CH*DIV_W  divisor values; channel i uses bits [i*DIV_W +: DIV_W].
- LOST_CLR  in  1  clears LOCK_LOST.
- TICK  out  NUM_CH  one-cycle enable strobes.
- CLK_OK  out  1  filtered lock status.
- LOCK_LOST  out  1  sticky loss-of-lock flag.

Behaviour:
- Reset is synchronous and active-low: RESETN=0 sampled at a CLK edge resets all state.
- Reset values:
  - TICK=0, CLK_OK=0, LOCK_LOST=0.
  - Sync flops=0, filter count=0, FSM=UNLOCKED.
  - Active and shadow divisors=DIV_RST, counters=0, shadow-pending=0.
- LOCK passes through a 2-FF synchronizer giving lock_s, which adds 2 cycles of latency.
- Lock FSM:
  - UNLOCKED: filter count=0; lock_s=1 -> SETTLING.
  - SETTLING: filter count increments each cycle lock_s=1. lock_s=0 -> UNLOCKED with count cleared. Count reaching LOCK_FILTER-1 while lock_s=1 -> LOCKED.
  - LOCKED: CLK_OK=1 (registered, asserted on FSM entry). lock_s=0 -> UNLOCKED; CLK_OK falls on the same edge and LOCK_LOST is set.
- LOCK_LOST:
  - Set on LOCKED->UNLOCKED.
  - Cleared by LOST_CLR=1.
  - Set takes priority when set and LOST_CLR occur on the same cycle.
- Channel run condition: run_i = CLK_OK & EN[i].
- Channel counter when run_i=1:
  - cnt==0: TICK[i]=1 for exactly one cycle, cnt<=div_eff-1.
  - Otherwise: cnt<=cnt-1, TICK[i]=0.
  - div_eff = max(div_active,1). Divisor 0 or 1 gives TICK high every cycle.
- Channel behaviour when run_i=0: cnt<=0, TICK[i]=0. The first tick after run_i rises occurs on the first enabled cycle (phase restart).
- Divisor load:
  - DIV_LD[i]=1 latches DIV_VAL slice into shadow_i and sets pending_i.
  - A pending shadow is copied to div_active on the next terminal count (cnt==0 with run_i=1), or on the next cycle if run_i=0. pending_i then clears.
  - The current period always completes with the old divisor; no runt tick.
  - A second DIV_LD before transfer overwrites the shadow; only the last value is used.
- Loss of lock mid-period: all counters clear and TICK stays 0. On relock, channels restart as a fresh enable.
- TICK is registered: one cycle latency from counter state.
- Arithmetic: counters are DIV_W bits unsigned. div_eff-1 never underflows because div_eff>=1.

Optional Feature:
- Macro: CCC_TICK_SQW_EN.
- When defined:
  - Adds output SQW (NUM_CH bits).
  - SQW[i] toggles on every TICK[i], giving a period of 2*div_eff cycles.
  - SQW[i] is forced to 0 when run_i=0 or under reset.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then relock: RESETN low 3 cycles, LOCK=1 from cycle 0, LOCK_FILTER=8 -> CLK_OK rises 2+8 cycles after reset release. TICK stays 0 before that. All outputs 0 during reset.
2. Divisor 4, EN[0]=1 after CLK_OK -> TICK[0] on the first enabled cycle, then every 4th cycle: relative cycles 0, 4, 8. Divisor 0 and divisor 1 on channel 1 -> TICK[1] every cycle.
3. Glitch-free reload: channel 0 running at div 10, DIV_LD with 3 at cycle 2 of a period -> next tick still at cycle 10, then ticks every 3 cycles. Two DIV_LD pulses (5 then 7) in one period -> period 7 used.
4. Lock glitch: LOCK low for 1 cycle during SETTLING (count=5) -> CLK_OK stays 0 and the filter restarts from 0. In LOCKED, LOCK low -> CLK_OK drops 2 cycles later, LOCK_LOST=1, all TICK=0, counters cleared.
5. LOST_CLR asserted in the same cycle as a new loss event -> LOCK_LOST remains 1. LOST_CLR alone -> LOCK_LOST=0 the next cycle.
6. With CCC_TICK_SQW_EN, div 3 -> SQW[0] has period 6 cycles at 50% duty. EN[0] deassert -> SQW[0]=0 the next cycle.

Source files
------------

// File: rtl/ccc_tick_gen.sv
// ccc_tick_gen: filtered CCC lock status plus NUM_CH programmable clock-enable
// tick strobes with glitch-free, shadow-buffered divisor reloads.
// Optional build macro CCC_TICK_SQW_EN adds a per-channel square-wave output SQW.
module ccc_tick_gen #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned LOCK_FILTER = 8,
   parameter int unsigned DIV_RST     = 1000
) (
   input  logic                      CLK,
   input  logic                      RESETN,
   input  logic                      LOCK,
   input  logic [NUM_CH-1:0]         EN,
   input  logic [NUM_CH-1:0]         DIV_LD,
   input  logic [NUM_CH*DIV_W-1:0]   DIV_VAL,
   input  logic                      LOST_CLR,
   output logic [NUM_CH-1:0]         TICK,
   output logic                      CLK_OK,
   output logic                      LOCK_LOST
`ifdef CCC_TICK_SQW_EN
   ,
   output logic [NUM_CH-1:0]         SQW
`endif
);

   localparam int unsigned FILT_W = 8;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SETTLING = 2'd1,
      ST_LOCKED   = 2'd2
   } lock_state_e;

   logic              lock_m;
   logic              lock_s;
   lock_state_e       state;
   lock_state_e       state_nx;
   logic [FILT_W-1:0] filt_cnt;
   logic [FILT_W-1:0] filt_nx;
   logic              lost_set;

   // Two-flop synchronizer for the asynchronous CCC lock
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= LOCK;
         lock_s <= lock_m;
      end
   end

   // Lock filter FSM: state, filter count and the registered status flags
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state     <= ST_UNLOCKED;
         filt_cnt  <= '0;
         CLK_OK    <= 1'b0;
         LOCK_LOST <= 1'b0;
      end else begin
         state    <= state_nx;
         filt_cnt <= filt_nx;
         CLK_OK   <= (state_nx == ST_LOCKED);
         if (lost_set) begin
            LOCK_LOST <= 1'b1;
         end else if (LOST_CLR) begin
            LOCK_LOST <= 1'b0;
         end
      end
   end

   // Next-state logic; the filter counts consecutive synchronized lock-high cycles
   always_comb begin
      state_nx = state;
      filt_nx  = filt_cnt;
      lost_set = 1'b0;
      unique case (state)
         ST_UNLOCKED: begin
            filt_nx = '0;
            if (lock_s) begin
               filt_nx  = FILT_W'(1);
               state_nx = (LOCK_FILTER <= 1) ? ST_LOCKED : ST_SETTLING;
            end
         end
         ST_SETTLING: begin
            if (!lock_s) begin
               state_nx = ST_UNLOCKED;
               filt_nx  = '0;
            end else if (filt_cnt == FILT_W'(LOCK_FILTER - 1)) begin
               state_nx = ST_LOCKED;
               filt_nx  = '0;
            end else begin
               filt_nx = filt_cnt + FILT_W'(1);
            end
         end
         ST_LOCKED: begin
            filt_nx = '0;
            if (!lock_s) begin
               state_nx = ST_UNLOCKED;
               lost_set = 1'b1;
            end
         end
         default: begin
            state_nx = ST_UNLOCKED;
            filt_nx  = '0;
         end
      endcase
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic             run;
      logic             tc;
      logic             xfer;
      logic             pend;
      logic             tick_r;
      logic [DIV_W-1:0] div_act;
      logic [DIV_W-1:0] div_shd;
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] div_next;
      logic [DIV_W-1:0] div_eff;

      assign run      = CLK_OK & EN[i];
      assign tc       = run && (cnt == '0);
      // A fresh load on the same cycle defers the transfer to the next opportunity
      assign xfer     = pend && !DIV_LD[i] && (tc || !run);
      assign div_next = xfer ? div_shd : div_act;
      assign div_eff  = (div_next == '0) ? DIV_W'(1) : div_next;
      assign TICK[i]  = tick_r;

      // Shadow/active divisor handling and the down-counting tick generator
      always_ff @(posedge CLK) begin
         if (!RESETN) begin
            div_act <= DIV_W'(DIV_RST);
            div_shd <= DIV_W'(DIV_RST);
            pend    <= 1'b0;
            cnt     <= '0;
            tick_r  <= 1'b0;
         end else begin
            if (DIV_LD[i]) begin
               div_shd <= DIV_VAL[i*DIV_W +: DIV_W];
               pend    <= 1'b1;
            end else if (xfer) begin
               div_act <= div_shd;
               pend    <= 1'b0;
            end
            if (!run) begin
               cnt    <= '0;
               tick_r <= 1'b0;
            end else if (tc) begin
               cnt    <= div_eff - DIV_W'(1);
               tick_r <= 1'b1;
            end else begin
               cnt    <= cnt - DIV_W'(1);
               tick_r <= 1'b0;
            end
         end
      end

`ifdef CCC_TICK_SQW_EN
      logic sqw_r;
      assign SQW[i] = sqw_r;

      // Square wave toggling on every tick, held low while the channel is idle
      always_ff @(posedge CLK) begin
         if (!RESETN || !run) begin
            sqw_r <= 1'b0;
         end else if (tc) begin
            sqw_r <= ~sqw_r;
         end
      end
`endif
   end

endmodule

// File: tb/tb_ccc_tick_gen.sv
// Bench for ccc_tick_gen: vector table, directed corner sequences and random
// stimulus, all checked against an elapsed-time reference model.
module tb_ccc_tick_gen;

   localparam int unsigned NUM_CH      = 4;
   localparam int unsigned DIV_W       = 16;
   localparam int unsigned LOCK_FILTER = 8;
   localparam int unsigned DIV_RST     = 1000;
   localparam int unsigned NROWS       = 30;

   logic                    CLK = 1'b0;
   logic                    RESETN;
   logic                    LOCK;
   logic [NUM_CH-1:0]       EN;
   logic [NUM_CH-1:0]       DIV_LD;
   logic [NUM_CH*DIV_W-1:0] DIV_VAL;
   logic                    LOST_CLR;
   logic [NUM_CH-1:0]       TICK;
   logic                    CLK_OK;
   logic                    LOCK_LOST;
`ifdef CCC_TICK_SQW_EN
   logic [NUM_CH-1:0]       SQW;
`endif

   ccc_tick_gen #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILTER(LOCK_FILTER), .DIV_RST(DIV_RST)
   ) dut (
      .CLK(CLK), .RESETN(RESETN), .LOCK(LOCK), .EN(EN), .DIV_LD(DIV_LD),
      .DIV_VAL(DIV_VAL), .LOST_CLR(LOST_CLR), .TICK(TICK), .CLK_OK(CLK_OK),
      .LOCK_LOST(LOCK_LOST)
`ifdef CCC_TICK_SQW_EN
      , .SQW(SQW)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: lock history, streak of lock-high cycles, and per-channel
   // elapsed time since the last tick versus the period in force.
   logic [1:0]        m_pipe;
   int                m_streak;
   logic              m_ok;
   logic              m_lost;
   int                m_act   [NUM_CH];
   int                m_shd   [NUM_CH];
   int                m_since [NUM_CH];
   int                m_per   [NUM_CH];
   logic              m_pend  [NUM_CH];
   logic [NUM_CH-1:0] m_tick;
   logic [NUM_CH-1:0] m_sqw;

   typedef struct {
      logic              rst;
      logic              lk;
      logic [NUM_CH-1:0] en;
      logic [NUM_CH-1:0] ld;
      int                val;
      logic              clr;
      logic              ok;
      logic              lost;
      logic [NUM_CH-1:0] tick;
   } vec_t;

   vec_t tbl [NROWS];

   function automatic int eff(input int d);
      return (d < 1) ? 1 : d;
   endfunction

   function automatic logic [NUM_CH*DIV_W-1:0] bval(input int v);
      logic [NUM_CH*DIV_W-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c*DIV_W +: DIV_W] = DIV_W'(v);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic lk, input logic [NUM_CH-1:0] en,
                             input logic [NUM_CH-1:0] ld, input logic [NUM_CH*DIV_W-1:0] val,
                             input logic clr);
      logic lock_s;
      logic run;
      logic new_ok;
      if (!rst) begin
         m_pipe   = '0;
         m_streak = 0;
         m_ok     = 1'b0;
         m_lost   = 1'b0;
         m_tick   = '0;
         m_sqw    = '0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_act[c]   = int'(DIV_RST);
            m_shd[c]   = int'(DIV_RST);
            m_since[c] = -1;
            m_per[c]   = 1;
            m_pend[c]  = 1'b0;
         end
      end else begin
         lock_s = m_pipe[1];
         for (int c = 0; c < NUM_CH; c++) begin
            run       = m_ok && en[c];
            m_tick[c] = 1'b0;
            if (run) begin
               if (m_since[c] < 0 || m_since[c] + 1 >= m_per[c]) begin
                  m_tick[c]  = 1'b1;
                  m_since[c] = 0;
                  if (m_pend[c] && !ld[c]) begin
                     m_act[c]  = m_shd[c];
                     m_pend[c] = 1'b0;
                  end
                  m_per[c] = eff(m_act[c]);
                  m_sqw[c] = ~m_sqw[c];
               end else begin
                  m_since[c]++;
               end
            end else begin
               m_since[c] = -1;
               m_sqw[c]   = 1'b0;
               if (m_pend[c] && !ld[c]) begin
                  m_act[c]  = m_shd[c];
                  m_pend[c] = 1'b0;
               end
            end
            if (ld[c]) begin
               m_shd[c]  = int'(val[c*DIV_W +: DIV_W]);
               m_pend[c] = 1'b1;
            end
         end
         if (lock_s) m_streak = (m_streak < 1000) ? m_streak + 1 : m_streak;
         else        m_streak = 0;
         new_ok = (m_streak >= int'(LOCK_FILTER));
         if (m_ok && !new_ok) m_lost = 1'b1;
         else if (clr)        m_lost = 1'b0;
         m_ok   = new_ok;
         m_pipe = {m_pipe[0], lk};
      end
   endtask

   // Drive one cycle of inputs, clock, then compare all outputs with the model
   task automatic step(input logic rst, input logic lk, input logic [NUM_CH-1:0] en,
                       input logic [NUM_CH-1:0] ld, input logic [NUM_CH*DIV_W-1:0] val,
                       input logic clr);
      RESETN   = rst;
      LOCK     = lk;
      EN       = en;
      DIV_LD   = ld;
      DIV_VAL  = val;
      LOST_CLR = clr;
      @(posedge CLK);
      #1;
      cyc++;
      model_step(rst, lk, en, ld, val, clr);
      chk("model_tick", 32'(TICK), 32'(m_tick));
      chk("model_clk_ok", 32'(CLK_OK), 32'(m_ok));
      chk("model_lock_lost", 32'(LOCK_LOST), 32'(m_lost));
`ifdef CCC_TICK_SQW_EN
      chk("model_sqw", 32'(SQW), 32'(m_sqw));
`endif
   endtask

   logic              rl;
   logic              rclr;
   logic              rrst;
   logic [NUM_CH-1:0] ren;
   logic [NUM_CH-1:0] rld;
   logic [NUM_CH*DIV_W-1:0] rval;
   logic              exp_t;

   initial begin
      // Reset, lock filter, divisor 4 on ch0, divisors 0 and 1 on ch1
      for (int r = 0; r < int'(NROWS); r++) begin
         tbl[r].rst  = (r >= 3);
         tbl[r].lk   = 1'b1;
         tbl[r].en   = (r >= 23) ? 4'b0011 : (r >= 13) ? 4'b0001 : 4'b0000;
         tbl[r].ld   = '0;
         tbl[r].val  = 0;
         tbl[r].clr  = 1'b0;
         tbl[r].ok   = (r >= 12);
         tbl[r].lost = 1'b0;
         tbl[r].tick = '0;
         if (r == 13 || r == 17 || r == 21 || r == 25 || r == 29) tbl[r].tick[0] = 1'b1;
         if (r >= 23) tbl[r].tick[1] = 1'b1;
      end
      tbl[5].ld  = 4'b1111; tbl[5].val  = 4;
      tbl[22].ld = 4'b0010; tbl[22].val = 0;
      tbl[26].ld = 4'b0010; tbl[26].val = 1;

      for (int r = 0; r < int'(NROWS); r++) begin
         step(tbl[r].rst, tbl[r].lk, tbl[r].en, tbl[r].ld, bval(tbl[r].val), tbl[r].clr);
         chk($sformatf("tbl%0d_clk_ok", r), 32'(CLK_OK), 32'(tbl[r].ok));
         chk($sformatf("tbl%0d_lock_lost", r), 32'(LOCK_LOST), 32'(tbl[r].lost));
         chk($sformatf("tbl%0d_tick", r), 32'(TICK), 32'(tbl[r].tick));
      end

      // Glitch-free reload: 10 -> 3 mid-period, then 5 overwritten by 7
      step(1'b1, 1'b1, 4'b0010, 4'b0001, bval(10), 1'b0);
      step(1'b1, 1'b1, 4'b0010, 4'b0000, bval(0), 1'b0);
      for (int k = 0; k <= 33; k++) begin
         rld  = (k == 2 || k == 17 || k == 18) ? 4'b0001 : 4'b0000;
         rval = bval((k == 2) ? 3 : (k == 17) ? 5 : 7);
         step(1'b1, 1'b1, 4'b0011, rld, rval, 1'b0);
         exp_t = (k == 0 || k == 10 || k == 13 || k == 16 || k == 19 || k == 26 || k == 33);
         chk($sformatf("reload_k%0d_tick0", k), 32'(TICK[0]), 32'(exp_t));
      end

      // Loss of lock while locked
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b0);
      chk("loss_ok_hold1", 32'(CLK_OK), 32'd1);
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b0);
      chk("loss_ok_hold2", 32'(CLK_OK), 32'd1);
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b0);
      chk("loss_ok_drop", 32'(CLK_OK), 32'd0);
      chk("loss_lost_set", 32'(LOCK_LOST), 32'd1);
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b0);
      chk("loss_tick_quiet", 32'(TICK), 32'd0);
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b1);
      chk("lost_clr_alone", 32'(LOCK_LOST), 32'd0);

      // One-cycle LOCK glitch at filter count 5 restarts the filter
      for (int j = 0; j <= 16; j++) begin
         step(1'b1, (j != 5), 4'b0011, 4'b0000, bval(0), 1'b0);
         chk($sformatf("glitch_j%0d_clk_ok", j), 32'(CLK_OK), 32'(j >= 15));
      end

      // LOST_CLR coinciding with a new loss: set wins
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b0);
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b0);
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b1);
      chk("set_beats_clr_ok", 32'(CLK_OK), 32'd0);
      chk("set_beats_clr_lost", 32'(LOCK_LOST), 32'd1);
      step(1'b1, 1'b0, 4'b0011, 4'b0000, bval(0), 1'b1);
      chk("clr_after_set", 32'(LOCK_LOST), 32'd0);
      for (int j = 0; j < 12; j++) step(1'b1, 1'b1, 4'b0000, 4'b0000, bval(0), 1'b0);
      chk("relock_ok", 32'(CLK_OK), 32'd1);

`ifdef CCC_TICK_SQW_EN
      // Square wave at divisor 3 and forced low on disable
      step(1'b1, 1'b1, 4'b0000, 4'b0001, bval(3), 1'b0);
      step(1'b1, 1'b1, 4'b0000, 4'b0000, bval(0), 1'b0);
      for (int k = 0; k < 12; k++) begin
         step(1'b1, 1'b1, 4'b0001, 4'b0000, bval(0), 1'b0);
         chk($sformatf("sqw_k%0d", k), 32'(SQW[0]), 32'(((k / 3) % 2) == 0));
      end
      step(1'b1, 1'b1, 4'b0000, 4'b0000, bval(0), 1'b0);
      chk("sqw_disable", 32'(SQW[0]), 32'd0);
`endif

      // Randomized traffic against the model, with a mid-run reset
      rl  = 1'b1;
      ren = 4'b1111;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 149) == 0) rl = ~rl;
         rld = '0;
         for (int c = 0; c < int'(NUM_CH); c++) begin
            if ($urandom_range(0, 29) == 0) ren[c] = ~ren[c];
            rld[c] = ($urandom_range(0, 19) == 0);
            rval[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
         end
         rclr = ($urandom_range(0, 24) == 0);
         rrst = !(n == 1500 || n == 1501);
         step(rrst, rl, ren, rld, rval, rclr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
